rx_crc_frame: RTL and testbench
===============================

# rx_crc_frame

UART receiver and frame decoder for command frames with CRC16 check; the inbound counterpart of the response transmitter. It deserialises bytes on `URXD`, decodes the fields (com, lbl, address, write data), computes the same bit-serial CRC16 as the transmitter, and ends each frame with a one-cycle verdict. A `frame_ok` pulse serves directly as the `st` launch for the response transmitter; `com`, `lbl` and `adr` stay stable until the next frame starts.

## Interface
- `NT`, default `` `Nt `` (CONST.v): clocks per bit; must be ≥ 4.
- `INIT_CRC`, default `` `INIT_CRC `` (CONST.v): CRC preset value.
- `XCRC16`, default `` `XCRC16 `` (CONST.v): CRC polynomial constant.
- `clk  in  1`: single clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `URXD  in  1`: serial input; idle is 1.
- `en_rx  out  1`: frame in progress.
- `com  out  8`: command byte.
- `lbl  out  8`: data block length.
- `adr  out  16`: start address.
- `wr_dat  out  8`: received write-data byte.
- `wr_adr  out  16`: address of `wr_dat`.
- `we  out  1`: one-cycle write strobe.
- `frame_ok  out  1`: one-cycle pulse, frame complete and CRC matched.
- `crc_err  out  1`: one-cycle pulse, frame complete and CRC mismatched.
- `rx_err  out  1`: one-cycle pulse on framing error or timeout.
- `CRC  out  16`: running CRC.

## Operation
- **Input sync:** `URXD` passes through a 2-flop synchroniser; all logic uses the synchronised value.
- **Bit level:**
  - A falling edge while idle starts the bit counter `cb_tact`.
  - At `NT/2` the start bit is re-sampled; a 1 there is a glitch, so discard it and return to idle with no error.
  - Data bits are sampled every `NT` clocks after that, LSB first.
  - The stop bit is sampled at the next `NT` and must be 1; a 0 pulses `rx_err` and aborts the frame.
- **Byte states:** IDLE → COM → LBL → ADR_H → ADR_L → DATA → CRC_L → CRC_H → IDLE. Each transition occurs on a valid stop sample.
- **Frame length** is set by `com`:
  - read, `com` = 0x80 or 0x81: COM, LBL, ADR_H, ADR_L, then CRC.
  - write, `com` = 0x00 or 0x01: the same four bytes, then `lbl` DATA bytes, then CRC. If `lbl` = 0, go straight from ADR_L to CRC_L.
  - any other `com`: COM, then CRC_L directly.
- **CRC accumulation:**
  - Preset to `INIT_CRC` on the start bit of COM.
  - Updated once per data-bit sample for every byte before CRC_L, with `x0 = CRC[0] ^ bit`:
    - if `x0` = 1: `CRC <= ((CRC ^ XCRC16) >> 1) | 16'h8000`
    - else: `CRC <= CRC >> 1`
  - Frozen during CRC_L and CRC_H.
  - Received check value is `{CRC_H byte, CRC_L byte}`, compared against the frozen CRC.
- **Write data:**
  - `wr_adr` loads `adr` at the end of ADR_L.
  - Each DATA byte drives `wr_dat` and pulses `we` once.
  - `wr_adr` increments after each `we` and wraps from 0xFFFF to 0x0000.
  - Writes are not buffered. They are issued before the CRC verdict, and the consumer gates commit on `frame_ok`.
- **Timeout:** inside a frame, more than `20*NT` clocks from one stop sample to the next start edge pulses `rx_err` and returns to IDLE.
- **Reset values:**
  - all pulse outputs 0; `en_rx` 0;
  - `com`, `lbl`, `wr_dat` 0; `adr`, `wr_adr` 0;
  - `CRC` = `INIT_CRC`; state IDLE.

## Timing
- A byte is complete on the clock of its stop sample, about `9.5*NT` clocks after the start edge plus 2 clocks of synchroniser delay.
- `we` is asserted on the clock after a DATA stop sample; `wr_dat` and `wr_adr` are valid in that same cycle.
- `frame_ok` or `crc_err` is asserted on the clock after the CRC_H stop sample. The same edge deasserts `en_rx`.
- `en_rx` rises on the clock after the COM start bit is confirmed at `NT/2`.
- Field outputs update on the clock after their byte's stop sample:
  - `com` and `lbl` are held until the next COM completes.
  - `adr` is held until the next ADR_L completes.
- **Next frame:** a start edge is accepted one clock after CRC_H, so back-to-back frames with zero idle bits are legal.
- **Error abort:** `rx_err` asserts with no `frame_ok` or `crc_err`, and `en_rx` drops the same cycle.
- **Reset during a frame:** the frame is abandoned and no pulse is emitted.

## Test plan
- **Write frame** (NT=8): 0x00, 0x02, 0x12, 0x34, 0xA5, 0x5A, correct CRC → two `we` pulses, (0x1234, 0xA5) then (0x1235, 0x5A), then `frame_ok`=1; `com`=0x00, `lbl`=0x02.
- **Corrupted CRC:** the same frame with CRC_L bit 0 flipped → both `we` pulses, `crc_err`=1, `frame_ok` never asserted.
- **Read and foreign frames:** 0x80, 0x10, 0xAB, 0xCD, CRC → `frame_ok`, no `we`, `adr`=0xABCD. Then 0x55 followed by its 2 CRC bytes → `frame_ok` after the 3rd byte.
- **Framing error and recovery:** stop bit 0 in byte 2 → `rx_err`, return to IDLE; a following valid frame → `frame_ok`.
- **Glitch and timeout:** a low pulse of `NT/4` on idle `URXD` → no `en_rx`. A stall of `25*NT` after ADR_H → `rx_err`.
- **Reset and wrap:** `rst_n` low mid-DATA → all outputs at reset values and no pulses. A write to 0xFFFF with `lbl`=2 → `wr_adr` 0xFFFF, then 0x0000.

Source files
------------

// File: rtl/rx_crc_frame_if.sv
// Serial command-frame receiver bus: URXD in, decoded fields, strobes and verdicts out.
// master is the receiver side, slave is the line driver / frame consumer.
interface rx_crc_frame_if;
    logic        URXD;
    logic        en_rx;
    logic [7:0]  com;
    logic [7:0]  lbl;
    logic [15:0] adr;
    logic [7:0]  wr_dat;
    logic [15:0] wr_adr;
    logic        we;
    logic        frame_ok;
    logic        crc_err;
    logic        rx_err;
    logic [15:0] CRC;

    modport master (
        input  URXD,
        output en_rx, com, lbl, adr, wr_dat, wr_adr, we, frame_ok, crc_err, rx_err, CRC
    );

    modport slave (
        output URXD,
        input  en_rx, com, lbl, adr, wr_dat, wr_adr, we, frame_ok, crc_err, rx_err, CRC
    );
endinterface

// File: rtl/rx_crc_frame.sv
// UART receiver and command-frame decoder with bit-serial CRC16 check.
// Emits write strobes per DATA byte and a one-cycle frame_ok / crc_err / rx_err verdict.
module rx_crc_frame #(
    parameter int unsigned NT       = 8,
    parameter logic [15:0] INIT_CRC = 16'hFFFF,
    parameter logic [15:0] XCRC16   = 16'h4002
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rx_crc_frame_if.master        bus
);
    localparam int unsigned HALF = NT / 2;
    localparam int unsigned CBW  = $clog2(NT + 1);
    localparam int unsigned TMO  = 20 * NT;
    localparam int unsigned TW   = $clog2(TMO + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_COM, S_LBL, S_ADR_H, S_ADR_L, S_DATA, S_CRC_L, S_CRC_H
    } state_t;

    state_t         state_q;
    logic           rxd_s1_q, rxd_s2_q, rxd_s3_q;
    logic           busy_q;
    logic [CBW-1:0] cb_tact_q;
    logic [3:0]     bit_idx_q;
    logic [7:0]     shift_q;
    logic [7:0]     adr_h_q;
    logic [7:0]     crc_lo_q;
    logic [7:0]     data_cnt_q;
    logic [TW-1:0]  tmo_q;

    logic           en_rx_q, we_q, frame_ok_q, crc_err_q, rx_err_q;
    logic [7:0]     com_q, lbl_q, wr_dat_q;
    logic [15:0]    adr_q, wr_adr_q, crc_q;

    logic           start_edge_c;
    logic           sample_c;
    logic           x0_c;
    logic [15:0]    crc_next_c;

    // Falling edge on the synchronised line while the bit engine is free.
    assign start_edge_c = !busy_q && !rxd_s2_q && rxd_s3_q;
    assign sample_c     = busy_q &&
                          (cb_tact_q == ((bit_idx_q == 4'd0) ? CBW'(HALF) : CBW'(NT)));
    assign x0_c         = crc_q[0] ^ rxd_s2_q;
    assign crc_next_c   = x0_c ? (((crc_q ^ XCRC16) >> 1) | 16'h8000) : (crc_q >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_s3_q   <= 1'b1;
            busy_q     <= 1'b0;
            cb_tact_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            adr_h_q    <= '0;
            crc_lo_q   <= '0;
            data_cnt_q <= '0;
            tmo_q      <= '0;
            en_rx_q    <= 1'b0;
            we_q       <= 1'b0;
            frame_ok_q <= 1'b0;
            crc_err_q  <= 1'b0;
            rx_err_q   <= 1'b0;
            com_q      <= '0;
            lbl_q      <= '0;
            wr_dat_q   <= '0;
            adr_q      <= '0;
            wr_adr_q   <= '0;
            crc_q      <= INIT_CRC;
        end else begin
            rxd_s1_q   <= bus.URXD;
            rxd_s2_q   <= rxd_s1_q;
            rxd_s3_q   <= rxd_s2_q;
            we_q       <= 1'b0;
            frame_ok_q <= 1'b0;
            crc_err_q  <= 1'b0;
            rx_err_q   <= 1'b0;

            if (we_q) begin
                wr_adr_q <= wr_adr_q + 16'd1;
            end

            if (start_edge_c) begin
                busy_q    <= 1'b1;
                cb_tact_q <= CBW'(1);
                bit_idx_q <= '0;
                tmo_q     <= '0;
            end else if (busy_q) begin
                if (!sample_c) begin
                    cb_tact_q <= cb_tact_q + CBW'(1);
                end else begin
                    cb_tact_q <= CBW'(1);
                    bit_idx_q <= bit_idx_q + 4'd1;
                    if (bit_idx_q == 4'd0) begin
                        // Start bit re-check: high here means a glitch, drop silently.
                        if (rxd_s2_q) begin
                            busy_q <= 1'b0;
                        end else if (state_q == S_IDLE) begin
                            state_q <= S_COM;
                            en_rx_q <= 1'b1;
                            crc_q   <= INIT_CRC;
                        end
                    end else if (bit_idx_q != 4'd9) begin
                        shift_q <= {rxd_s2_q, shift_q[7:1]};
                        if (state_q != S_CRC_L && state_q != S_CRC_H) begin
                            crc_q <= crc_next_c;
                        end
                    end else begin
                        busy_q <= 1'b0;
                        tmo_q  <= '0;
                        if (!rxd_s2_q) begin
                            rx_err_q <= 1'b1;
                            en_rx_q  <= 1'b0;
                            state_q  <= S_IDLE;
                        end else begin
                            // Byte complete: route by frame position.
                            case (state_q)
                                S_COM: begin
                                    com_q   <= shift_q;
                                    state_q <= (shift_q[6:1] == 6'd0) ? S_LBL : S_CRC_L;
                                end
                                S_LBL: begin
                                    lbl_q   <= shift_q;
                                    state_q <= S_ADR_H;
                                end
                                S_ADR_H: begin
                                    adr_h_q <= shift_q;
                                    state_q <= S_ADR_L;
                                end
                                S_ADR_L: begin
                                    adr_q      <= {adr_h_q, shift_q};
                                    wr_adr_q   <= {adr_h_q, shift_q};
                                    data_cnt_q <= lbl_q;
                                    state_q    <= (!com_q[7] && lbl_q != 8'd0) ? S_DATA : S_CRC_L;
                                end
                                S_DATA: begin
                                    wr_dat_q   <= shift_q;
                                    we_q       <= 1'b1;
                                    data_cnt_q <= data_cnt_q - 8'd1;
                                    if (data_cnt_q == 8'd1) begin
                                        state_q <= S_CRC_L;
                                    end
                                end
                                S_CRC_L: begin
                                    crc_lo_q <= shift_q;
                                    state_q  <= S_CRC_H;
                                end
                                S_CRC_H: begin
                                    frame_ok_q <= ({shift_q, crc_lo_q} == crc_q);
                                    crc_err_q  <= ({shift_q, crc_lo_q} != crc_q);
                                    en_rx_q    <= 1'b0;
                                    state_q    <= S_IDLE;
                                end
                                default: begin
                                    state_q <= S_IDLE;
                                end
                            endcase
                        end
                    end
                end
            end else if (state_q != S_IDLE) begin
                // Inter-byte gap watchdog inside a frame.
                if (tmo_q == TW'(TMO)) begin
                    rx_err_q <= 1'b1;
                    en_rx_q  <= 1'b0;
                    state_q  <= S_IDLE;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
            end
        end
    end

    assign bus.en_rx    = en_rx_q;
    assign bus.com      = com_q;
    assign bus.lbl      = lbl_q;
    assign bus.adr      = adr_q;
    assign bus.wr_dat   = wr_dat_q;
    assign bus.wr_adr   = wr_adr_q;
    assign bus.we       = we_q;
    assign bus.frame_ok = frame_ok_q;
    assign bus.crc_err  = crc_err_q;
    assign bus.rx_err   = rx_err_q;
    assign bus.CRC      = crc_q;
endmodule

// File: tb/tb_rx_crc_frame.sv
// Directed bench for rx_crc_frame: serialises frames on URXD and checks decoded fields and verdicts.
module tb_rx_crc_frame;
    localparam int unsigned NT = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rx_crc_frame_if bus ();

    rx_crc_frame #(.NT(NT), .INIT_CRC(16'hFFFF), .XCRC16(16'h4002)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Event log collected away from the active edge.
    int          we_cnt = 0, ok_cnt = 0, cerr_cnt = 0, rerr_cnt = 0, en_cnt = 0;
    logic        en_prev = 1'b0;
    logic [7:0]  wd_log[$];
    logic [15:0] wa_log[$];

    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            we_cnt++;
            wd_log.push_back(bus.wr_dat);
            wa_log.push_back(bus.wr_adr);
        end
        if (bus.frame_ok === 1'b1) ok_cnt++;
        if (bus.crc_err === 1'b1) cerr_cnt++;
        if (bus.rx_err === 1'b1) rerr_cnt++;
        if (bus.en_rx === 1'b1 && !en_prev) en_cnt++;
        en_prev = (bus.en_rx === 1'b1);
    end

    int b_we, b_ok, b_cerr, b_rerr, b_en;
    logic [7:0]  fb[$];
    logic [15:0] crc_exp;

    task automatic snap();
        b_we = we_cnt; b_ok = ok_cnt; b_cerr = cerr_cnt; b_rerr = rerr_cnt; b_en = en_cnt;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = ((r ^ 16'h4002) >> 1) | 16'h8000;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.URXD = 1'b0;
        repeat (NT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.URXD = b[i];
            repeat (NT) @(negedge clk);
        end
        bus.URXD = stop;
        repeat (NT) @(negedge clk);
        bus.URXD = 1'b1;
    endtask

    task automatic send_frame(input logic [15:0] flip, output logic [15:0] crc);
        crc = 16'hFFFF;
        foreach (fb[i]) begin
            crc = crc_byte(crc, fb[i]);
            send_byte(fb[i], 1'b1);
        end
        send_byte(crc[7:0] ^ flip[7:0], 1'b1);
        send_byte(crc[15:8] ^ flip[15:8], 1'b1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bus.URXD = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_en_rx", 32'(bus.en_rx), 0);
        chk("rst_com", 32'(bus.com), 0);
        chk("rst_adr", 32'(bus.adr), 0);
        chk("rst_wr_adr", 32'(bus.wr_adr), 0);
        chk("rst_crc", 32'(bus.CRC), 32'hFFFF);
        chk("rst_pulses", 32'({bus.we, bus.frame_ok, bus.crc_err, bus.rx_err}), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Write frame, two data bytes
        snap();
        fb = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hA5, 8'h5A};
        send_frame(16'h0000, crc_exp);
        chk("wr_we_n", 32'(we_cnt - b_we), 2);
        chk("wr_dat0", 32'(wd_log[b_we]), 32'hA5);
        chk("wr_adr0", 32'(wa_log[b_we]), 32'h1234);
        chk("wr_dat1", 32'(wd_log[b_we + 1]), 32'h5A);
        chk("wr_adr1", 32'(wa_log[b_we + 1]), 32'h1235);
        chk("wr_ok_n", 32'(ok_cnt - b_ok), 1);
        chk("wr_cerr_n", 32'(cerr_cnt - b_cerr), 0);
        chk("wr_en_rise", 32'(en_cnt - b_en), 1);
        chk("wr_com", 32'(bus.com), 32'h00);
        chk("wr_lbl", 32'(bus.lbl), 32'h02);
        chk("wr_adr", 32'(bus.adr), 32'h1234);
        chk("wr_crc", 32'(bus.CRC), 32'(crc_exp));
        chk("wr_en_end", 32'(bus.en_rx), 0);

        // Same frame, CRC_L bit 0 flipped
        snap();
        send_frame(16'h0001, crc_exp);
        chk("bad_we_n", 32'(we_cnt - b_we), 2);
        chk("bad_cerr_n", 32'(cerr_cnt - b_cerr), 1);
        chk("bad_ok_n", 32'(ok_cnt - b_ok), 0);

        // Read frame
        snap();
        fb = '{8'h80, 8'h10, 8'hAB, 8'hCD};
        send_frame(16'h0000, crc_exp);
        chk("rd_ok_n", 32'(ok_cnt - b_ok), 1);
        chk("rd_we_n", 32'(we_cnt - b_we), 0);
        chk("rd_adr", 32'(bus.adr), 32'hABCD);
        chk("rd_com", 32'(bus.com), 32'h80);
        chk("rd_lbl", 32'(bus.lbl), 32'h10);

        // Foreign command, CRC follows COM directly
        snap();
        fb = '{8'h55};
        send_frame(16'h0000, crc_exp);
        chk("fg_ok_n", 32'(ok_cnt - b_ok), 1);
        chk("fg_com", 32'(bus.com), 32'h55);
        chk("fg_crc", 32'(bus.CRC), 32'(crc_exp));
        chk("fg_adr_held", 32'(bus.adr), 32'hABCD);

        // Stop bit 0 in byte 2, then recovery
        snap();
        send_byte(8'h80, 1'b1);
        send_byte(8'h10, 1'b0);
        repeat (2 * NT) @(negedge clk);
        chk("fe_rerr_n", 32'(rerr_cnt - b_rerr), 1);
        chk("fe_ok_n", 32'(ok_cnt - b_ok + cerr_cnt - b_cerr), 0);
        chk("fe_en_rx", 32'(bus.en_rx), 0);
        snap();
        fb = '{8'h81, 8'h01, 8'h00, 8'h20};
        send_frame(16'h0000, crc_exp);
        chk("rec_ok_n", 32'(ok_cnt - b_ok), 1);
        chk("rec_adr", 32'(bus.adr), 32'h0020);

        // Short low glitch on idle line
        snap();
        bus.URXD = 1'b0;
        repeat (NT / 4) @(negedge clk);
        bus.URXD = 1'b1;
        repeat (4 * NT) @(negedge clk);
        chk("gl_en_rise", 32'(en_cnt - b_en), 0);
        chk("gl_rerr_n", 32'(rerr_cnt - b_rerr), 0);

        // Stall after ADR_H
        snap();
        send_byte(8'h80, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'hEE, 1'b1);
        repeat (25 * NT) @(negedge clk);
        chk("to_rerr_n", 32'(rerr_cnt - b_rerr), 1);
        chk("to_ok_n", 32'(ok_cnt - b_ok), 0);
        chk("to_en_rx", 32'(bus.en_rx), 0);
        chk("to_adr_held", 32'(bus.adr), 32'h0020);

        // Reset in the middle of a DATA byte
        snap();
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        bus.URXD = 1'b0;
        repeat (NT) @(negedge clk);
        bus.URXD = 1'b1;
        repeat (3 * NT) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("mr_en_rx", 32'(bus.en_rx), 0);
        chk("mr_com", 32'(bus.com), 0);
        chk("mr_lbl", 32'(bus.lbl), 0);
        chk("mr_adr", 32'(bus.adr), 0);
        chk("mr_wr_adr", 32'(bus.wr_adr), 0);
        chk("mr_crc", 32'(bus.CRC), 32'hFFFF);
        rst_n = 1'b1;
        repeat (12 * NT) @(negedge clk);
        chk("mr_pulses", 32'(we_cnt - b_we + ok_cnt - b_ok + cerr_cnt - b_cerr + rerr_cnt - b_rerr), 0);

        // Address wrap across 0xFFFF
        snap();
        fb = '{8'h01, 8'h02, 8'hFF, 8'hFF, 8'h11, 8'h22};
        send_frame(16'h0000, crc_exp);
        chk("wrap_we_n", 32'(we_cnt - b_we), 2);
        chk("wrap_adr0", 32'(wa_log[b_we]), 32'hFFFF);
        chk("wrap_dat0", 32'(wd_log[b_we]), 32'h11);
        chk("wrap_adr1", 32'(wa_log[b_we + 1]), 32'h0000);
        chk("wrap_dat1", 32'(wd_log[b_we + 1]), 32'h22);
        chk("wrap_ok_n", 32'(ok_cnt - b_ok), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
